// File: rtl/seq_ctrl_if.sv
// Bus bundle between seq_ctrl and its instruction memory / ALU.
//   imem_req   : fetch request (sequencer -> memory)
//   imem_addr  : fetch address, equal to the PC (sequencer -> memory)
//   imem_valid : fetch data valid (memory -> sequencer)
//   imem_data  : 16-bit instruction word (memory -> sequencer)
//   alu_a/b    : 9-bit ALU operands (sequencer -> ALU)
//   alu_opcode : 4-bit ALU opcode (sequencer -> ALU)
//   alu_out    : 9-bit combinational ALU result (ALU -> sequencer)
// master = sequencer side, slave = memory/ALU side.
interface seq_ctrl_if;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [8:0]  alu_a;
    logic [8:0]  alu_b;
    logic [3:0]  alu_opcode;
    logic [8:0]  alu_out;

    modport master (
        output imem_req, imem_addr, alu_a, alu_b, alu_opcode,
        input  imem_valid, imem_data, alu_out
    );

    modport slave (
        input  imem_req, imem_addr, alu_a, alu_b, alu_opcode,
        output imem_valid, imem_data, alu_out
    );
endinterface

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer feeding the 9-bit ALU.
// Fetches 16-bit instructions, decodes them, drives the ALU operands from a
// 4x9-bit register file and writes the ALU result back. One instruction at a
// time: FETCH -> DECODE -> EXEC -> WB, stopping in HALT on opcode F.
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset, clears all state
//   start       : level, sampled in IDLE/HALT, starts execution at PC=0
//   bus         : seq_ctrl_if master (instruction fetch + ALU operands/result)
//   dbg_sel     : register index for debug read
//   dbg_data    : combinational R[dbg_sel]
//   busy        : high in FETCH/DECODE/EXEC/WB
//   halted      : high in HALT
//   instr_count : retired instruction count, wraps 255->0
module seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    seq_ctrl_if.master  bus,
    input  logic [1:0]  dbg_sel,
    output logic [8:0]  dbg_data,
    output logic        busy,
    output logic        halted,
    output logic [7:0]  instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q;
    logic [7:0]  pc_q;
    logic [7:0]  pc_d;
    logic [15:0] ir_q;
    logic [8:0]  rf_q [4];
    logic [8:0]  result_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [8:0]  alu_a_q;
    logic [8:0]  alu_b_q;
    logic [3:0]  alu_op_q;

    logic [3:0]  ir_op;
    logic [1:0]  ir_rd;
    logic [1:0]  ir_rs;
    logic [7:0]  ir_imm;
    logic [8:0]  alu_b_d;
    logic        wr_en;

    assign ir_op  = ir_q[15:12];
    assign ir_rd  = ir_q[11:10];
    assign ir_rs  = ir_q[9:8];
    assign ir_imm = ir_q[7:0];

    always_comb begin
        pc_d  = pc_q + 8'd1;
        cnt_d = cnt_q + 8'd1;
        // Register-register forms (0-7) take R[rs]; everything else takes the
        // zero-extended immediate (only 8/9/A actually consume it).
        if (ir_op <= 4'h7) begin
            alu_b_d = rf_q[ir_rs];
        end else begin
            alu_b_d = {1'b0, ir_imm};
        end
        wr_en = (ir_op <= 4'hA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc_q    <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_valid) begin
                        ir_q    <= bus.imem_data;
                        pc_q    <= pc_d;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_a_q  <= rf_q[ir_rd];
                    alu_b_q  <= alu_b_d;
                    alu_op_q <= ir_op;
                    // HALT retires here; it never reaches EXEC/WB.
                    if (ir_op == 4'hF) begin
                        cnt_q   <= cnt_d;
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q <= bus.alu_out;
                    state_q  <= S_WB;
                end
                S_WB: begin
                    if (wr_en) begin
                        rf_q[ir_rd] <= result_q;
                    end
                    cnt_q   <= cnt_d;
                    state_q <= S_FETCH;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req   = (state_q == S_FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;

    assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_EXEC)  || (state_q == S_WB);
    assign halted      = (state_q == S_HALT);
    assign instr_count = cnt_q;
    assign dbg_data    = rf_q[dbg_sel];

endmodule

// File: tb/tb_seq_ctrl.sv
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  dbg_sel;
    logic [1:0]  mon_sel = '0;
    logic [1:0]  stim_sel = '0;
    logic        use_stim = 1'b0;
    logic [8:0]  dbg_data;
    logic        busy;
    logic        halted;
    logic [7:0]  instr_count;

    seq_ctrl_if bus ();

    always #10 clk = ~clk;

    assign dbg_sel = use_stim ? stim_sel : mon_sel;

    // External ALU behaviour (the block downstream of the sequencer).
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b);
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return ~a;
            4'h3: return a + b;
            4'h4: return b;
            4'h5: return a << 1;
            4'h6: return a >> 1;
            4'h7: return a - b;
            4'h8: return a + b;
            4'h9: return a - b;
            4'hA: return b;
            default: return '0;
        endcase
    endfunction

    assign bus.alu_out = alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);

    seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bus         (bus),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  w;
    } fetch_t;

    typedef struct {
        int unsigned     cyc;
        logic [7:0]      cnt;
        logic [1:0]      bh;
        logic [3:0][8:0] regs;
    } rec_t;

    fetch_t      fq[$];
    rec_t        exp_q[$];
    int unsigned fidx = 0;

    logic [15:0] prog_q[$];
    int unsigned wait_q[$];
    logic [8:0]  m_r [4];
    logic [7:0]  m_cnt;
    int unsigned last_c0;
    int unsigned budget;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic at_slot();
        @(negedge clk);
        #6;
    endtask

    // Instruction-level reference: walks the program, producing one expected
    // retirement record (edge number, count, busy/halted, register file).
    task automatic launch();
        int unsigned c;
        rec_t r;
        c = cyc + 1;
        last_c0 = c;
        fidx = 0;
        foreach (prog_q[i]) begin
            logic [15:0] d;
            logic [3:0]  op;
            logic [8:0]  a, b;
            int unsigned w;
            d  = prog_q[i];
            w  = wait_q[i];
            op = d[15:12];
            fq.push_back({d, 8'(w)});
            m_cnt = m_cnt + 8'd1;
            if (op == 4'hF) begin
                r.cyc  = c + 2 + w;
                r.cnt  = m_cnt;
                r.bh   = 2'b01;
                r.regs = {m_r[3], m_r[2], m_r[1], m_r[0]};
                exp_q.push_back(r);
                c = c + 2 + w;
                break;
            end
            a = m_r[d[11:10]];
            b = (op <= 4'h7) ? m_r[d[9:8]] : {1'b0, d[7:0]};
            if (op <= 4'hA) m_r[d[11:10]] = alu_f(op, a, b);
            r.cyc  = c + 4 + w;
            r.cnt  = m_cnt;
            r.bh   = 2'b10;
            r.regs = {m_r[3], m_r[2], m_r[1], m_r[0]};
            exp_q.push_back(r);
            c = c + 4 + w;
        end
        budget = c - cyc + 20;
        prog_q.delete();
        wait_q.delete();
        start = 1'b1;
        at_slot();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            at_slot();
            n++;
        end
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL %s_timeout: %0d retirements outstanding, required 0", name, exp_q.size());
            exp_q.delete();
            fq.delete();
        end
    endtask

    task automatic read_reg(input int unsigned idx, output logic [8:0] v);
        use_stim = 1'b1;
        stim_sel = 2'(idx);
        #1;
        v = dbg_data;
        use_stim = 1'b0;
    endtask

    // Called at a stimulus slot; asserts reset mid-cycle and checks that
    // every output clears without waiting for a clock edge.
    task automatic do_reset();
        logic [8:0] v;
        reset = 1'b1;
        fq.delete();
        exp_q.delete();
        fidx = 0;
        m_cnt = '0;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        #2;
        chk("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_imem_addr", bus.imem_addr, 8'h00);
        chk("rst_alu_ops", {bus.alu_a, bus.alu_b, bus.alu_opcode}, 22'h0);
        chk("rst_busy_halted", {busy, halted}, 2'b00);
        chk("rst_instr_count", instr_count, 8'h00);
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            chk("rst_dbg_data", v, 9'h000);
        end
        repeat (2) @(negedge clk);
        #6;
        reset = 1'b0;
        repeat (3) at_slot();
        chk("idle_busy", busy, 1'b0);
        chk("idle_imem_req", bus.imem_req, 1'b0);
    endtask

    // Memory responder: serves the queued fetch stream with per-fetch waits,
    // checks the fetch address, and drives noise when no fetch is pending.
    initial begin
        int unsigned wcnt;
        fetch_t f;
        wcnt = 0;
        bus.imem_valid = 1'b0;
        bus.imem_data = '0;
        forever begin
            @(negedge clk);
            #7;
            if (reset) begin
                bus.imem_valid = 1'b0;
                wcnt = 0;
            end else if (bus.imem_req) begin
                if (fq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_fetch: addr %0h requested, required no fetch", bus.imem_addr);
                    bus.imem_valid = 1'b0;
                end else begin
                    f = fq[0];
                    chk("fetch_addr", bus.imem_addr, fidx[7:0]);
                    if (wcnt < f.w) begin
                        bus.imem_valid = 1'b0;
                        bus.imem_data = 16'($urandom);
                        wcnt++;
                    end else begin
                        bus.imem_valid = 1'b1;
                        bus.imem_data = f.d;
                        void'(fq.pop_front());
                        fidx++;
                        wcnt = 0;
                    end
                end
            end else begin
                if (wcnt != 0) begin
                    total_cnt++;
                    $display("FAIL imem_req_hold: req 0 during wait %0d, required 1", wcnt);
                    wcnt = 0;
                end
                bus.imem_valid = 1'($urandom);
                bus.imem_data = 16'($urandom);
            end
        end
    end

    // Monitor: each retirement (count change or halted rising) pops one record.
    initial begin
        logic [7:0]      prev_cnt;
        logic            prev_h;
        logic [7:0]      cnt_now;
        logic            h_now;
        logic            b_now;
        int unsigned     cyc_now;
        logic [3:0][8:0] got;
        rec_t            r;
        prev_cnt = '0;
        prev_h = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_cnt = '0;
                prev_h = 1'b0;
            end else begin
                cnt_now = instr_count;
                h_now = halted;
                b_now = busy;
                cyc_now = cyc;
                if (cnt_now !== prev_cnt || (h_now && !prev_h)) begin
                    for (int s = 0; s < 4; s++) begin
                        mon_sel = 2'(s);
                        #1;
                        got[s] = dbg_data;
                    end
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_retire: count %0d halted %0b, required no retire", cnt_now, h_now);
                    end else begin
                        r = exp_q.pop_front();
                        chk("retire_cycle", 64'(cyc_now), 64'(r.cyc));
                        chk("retire_count", cnt_now, r.cnt);
                        chk("retire_busy_halted", {b_now, h_now}, r.bh);
                        chk("retire_regs", got, r.regs);
                    end
                end
                prev_cnt = cnt_now;
                prev_h = h_now;
            end
        end
    end

    initial begin
        logic [8:0] v;
        int unsigned n;

        at_slot();
        do_reset();

        // Zero-wait program.
        prog_q = '{16'hA405, 16'h8403, 16'hA80A, 16'h7600, 16'hF000};
        wait_q = '{0, 0, 0, 0, 0};
        launch();
        wait_done("zero_wait");
        read_reg(1, v); chk("zw_R1", v, 9'h1FE);
        read_reg(2, v); chk("zw_R2", v, 9'h00A);
        chk("zw_halted", halted, 1'b1);
        chk("zw_count", instr_count, 8'd5);

        // Wait states on the MOVI fetch.
        at_slot();
        prog_q = '{16'hACFF, 16'hF000};
        wait_q = '{3, 0};
        launch();
        wait_done("wait_state");
        read_reg(3, v); chk("ws_R3", v, 9'h0FF);

        // Logic / shift / NOP-class.
        at_slot();
        prog_q = '{16'hA0F0, 16'hA43C, 16'h0100, 16'h5000, 16'hB000, 16'hC000, 16'hF000};
        wait_q = '{0, 1, 0, 2, 0, 0, 0};
        launch();
        wait_done("logic_shift");
        read_reg(0, v); chk("ls_R0", v, 9'h060);
        read_reg(1, v); chk("ls_R1", v, 9'h03C);

        // Randomized programs, each restarted from HALT.
        for (int run = 0; run < 6; run++) begin
            at_slot();
            n = $urandom_range(3, 10);
            for (int i = 0; i < int'(n); i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 14));
                prog_q.push_back({op, 12'($urandom)});
                wait_q.push_back($urandom_range(0, 3));
            end
            prog_q.push_back({4'hF, 12'($urandom)});
            wait_q.push_back($urandom_range(0, 3));
            launch();
            wait_done("random");
        end

        // Reset during WB of ADDI R1,1, then re-run from PC 0.
        at_slot();
        prog_q = '{16'h8401, 16'hF000};
        wait_q = '{0, 0};
        launch();
        n = 0;
        while (cyc < last_c0 + 3 && n < 20) begin
            at_slot();
            n++;
        end
        chk("wb_busy", busy, 1'b1);
        chk("wb_alu_opcode", bus.alu_opcode, 4'h8);
        do_reset();
        at_slot();
        prog_q = '{16'h8401, 16'hF000};
        wait_q = '{0, 0};
        launch();
        wait_done("rerun");
        read_reg(1, v); chk("rr_R1", v, 9'h001);

        // PC and instruction count wrap.
        at_slot();
        do_reset();
        at_slot();
        for (int i = 0; i < 256; i++) begin
            prog_q.push_back(16'hB000);
            wait_q.push_back(0);
        end
        prog_q.push_back(16'hF000);
        wait_q.push_back(0);
        launch();
        wait_done("pc_wrap");
        chk("wrap_halted", halted, 1'b1);
        chk("wrap_count", instr_count, 8'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
